servo_duty_ramp: RTL and testbench

//  Rate-limited duty-command generator sitting directly upstream of the pwm stage.

---
 rtl/servo_duty_ramp_pkg.sv | 47 ++++
 rtl/servo_duty_ramp_if.sv | 25 ++
 rtl/servo_duty_ramp_period_divider.sv | 24 ++
 rtl/servo_duty_ramp.sv | 96 +++++++++
 tb/tb_servo_duty_ramp.sv | 236 +++++++++++++++++++++++
 5 files changed

// File: rtl/servo_duty_ramp_pkg.sv
// Shared types, defaults and duty arithmetic helpers for servo_duty_ramp.
// ST_SWEEP is only reachable when SERVO_AUTO_SWEEP_EN is defined.
package servo_duty_ramp_pkg;

  localparam int unsigned DUTYWIDTH    = 10;
  localparam int unsigned DEF_DUTYLOW  = 52;
  localparam int unsigned DEF_DUTYHIGH = 102;

  typedef logic [DUTYWIDTH-1:0] duty_t;
  typedef logic [DUTYWIDTH:0]   wide_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RAMP,
    ST_SWEEP
  } state_t;

  function automatic duty_t clamp_duty(input duty_t v, input duty_t lo, input duty_t hi);
    if (v < lo) return lo;
    if (v > hi) return hi;
    return v;
  endfunction

  // All sums are taken one bit wider so a step near the top of the range cannot wrap.
  function automatic duty_t step_sat(input duty_t cur, input duty_t step, input logic up,
                                     input duty_t lo, input duty_t hi);
    wide_t sum;
    wide_t floor_w;
    sum     = {1'b0, cur} + {1'b0, step};
    floor_w = {1'b0, lo} + {1'b0, step};
    if (up) return (sum > {1'b0, hi}) ? hi : duty_t'(sum);
    return ({1'b0, cur} < floor_w) ? lo : duty_t'({1'b0, cur} - {1'b0, step});
  endfunction

  function automatic duty_t slew_toward(input duty_t cur, input duty_t tgt, input duty_t slew);
    wide_t c;
    wide_t t;
    wide_t s;
    c = {1'b0, cur};
    t = {1'b0, tgt};
    s = {1'b0, slew};
    if (t > c) return (t - c > s) ? duty_t'(c + s) : tgt;
    if (c > t) return (c - t > s) ? duty_t'(c - s) : tgt;
    return cur;
  endfunction

endpackage

// File: rtl/servo_duty_ramp_if.sv
// Command/status bundle between the step debouncer / host and servo_duty_ramp.
interface servo_duty_ramp_if;
  import servo_duty_ramp_pkg::*;

  logic  step_up;
  logic  step_dn;
  logic  tgt_valid;
  duty_t tgt_duty;
  logic  tgt_ready;
  logic  period_start;
  logic  sweep_en;
  duty_t duty;
  logic  busy;
  logic  at_limit;

  modport master (
    output step_up, step_dn, tgt_valid, tgt_duty, period_start, sweep_en,
    input  tgt_ready, duty, busy, at_limit
  );

  modport slave (
    input  step_up, step_dn, tgt_valid, tgt_duty, period_start, sweep_en,
    output tgt_ready, duty, busy, at_limit
  );
endinterface

// File: rtl/servo_duty_ramp_period_divider.sv
// Counts PWM period boundaries and flags every RATE_DIV-th one as a slew tick.
module period_divider #(
  parameter int unsigned RATE_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic period_start,
  output logic tick
);
  localparam int unsigned CW = (RATE_DIV > 1) ? $clog2(RATE_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(RATE_DIV - 1);

  logic [CW-1:0] count;

  assign tick = period_start && (count == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (period_start) begin
      count <= tick ? '0 : count + 1'b1;
    end
  end
endmodule

// File: rtl/servo_duty_ramp.sv
// Rate-limited duty command generator: slews duty toward a stepped or loaded target,
// only on PWM period boundaries. Define SERVO_AUTO_SWEEP_EN to build the autonomous sweep.
module servo_duty_ramp
  import servo_duty_ramp_pkg::*;
#(
  parameter int unsigned DUTYLOW  = DEF_DUTYLOW,
  parameter int unsigned DUTYHIGH = DEF_DUTYHIGH,
  parameter int unsigned DUTYSTEP = 1,
  parameter int unsigned SLEW     = 2,
  parameter int unsigned RATE_DIV = 4
) (
  input logic               clk,
  input logic               rst_n,
  servo_duty_ramp_if.slave  bus
);
  localparam duty_t LOW_D  = duty_t'(DUTYLOW);
  localparam duty_t HIGH_D = duty_t'(DUTYHIGH);
  localparam duty_t STEP_D = duty_t'(DUTYSTEP);
  localparam duty_t SLEW_D = duty_t'(SLEW);

  state_t state_q, state_nxt;
  duty_t  duty_q, duty_nxt;
  duty_t  target_q, target_nxt;
  logic   busy_q, limit_q, ready_q;
  logic   tick;

  period_divider #(.RATE_DIV(RATE_DIV)) u_div (
    .clk          (clk),
    .rst_n        (rst_n),
    .period_start (bus.period_start),
    .tick         (tick)
  );

`ifndef SERVO_AUTO_SWEEP_EN
  logic unused_sweep_en;
  assign unused_sweep_en = bus.sweep_en;
`endif

  // Duty follows the target that was registered before this tick, so a target change
  // made in the same cycle only steers the next tick.
  always_comb begin
    duty_nxt   = duty_q;
    target_nxt = target_q;
    if (tick && (duty_q != target_q)) begin
      duty_nxt = slew_toward(duty_q, target_q, SLEW_D);
    end
    if (state_q != ST_SWEEP) begin
      if (bus.tgt_valid && ready_q) begin
        target_nxt = clamp_duty(bus.tgt_duty, LOW_D, HIGH_D);
      end else if (bus.step_up && !bus.step_dn) begin
        target_nxt = step_sat(target_q, STEP_D, 1'b1, LOW_D, HIGH_D);
      end else if (bus.step_dn && !bus.step_up) begin
        target_nxt = step_sat(target_q, STEP_D, 1'b0, LOW_D, HIGH_D);
      end
    end
    state_nxt = (target_nxt != duty_nxt) ? ST_RAMP : ST_IDLE;
`ifdef SERVO_AUTO_SWEEP_EN
    if (state_q == ST_SWEEP) begin
      state_nxt = ST_SWEEP;
      if (duty_nxt == target_q) begin
        if (bus.sweep_en) begin
          target_nxt = (target_q == HIGH_D) ? LOW_D : HIGH_D;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
    end else if ((state_q == ST_IDLE) && bus.sweep_en) begin
      target_nxt = (duty_q == HIGH_D) ? LOW_D : HIGH_D;
      state_nxt  = ST_SWEEP;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      duty_q   <= LOW_D;
      target_q <= LOW_D;
      busy_q   <= 1'b0;
      limit_q  <= 1'b1;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      duty_q   <= duty_nxt;
      target_q <= target_nxt;
      busy_q   <= (target_nxt != duty_nxt);
      limit_q  <= (target_nxt == LOW_D) || (target_nxt == HIGH_D);
      ready_q  <= (state_nxt == ST_IDLE);
    end
  end

  assign bus.duty      = duty_q;
  assign bus.busy      = busy_q;
  assign bus.at_limit  = limit_q;
  assign bus.tgt_ready = ready_q;
endmodule

// File: tb/tb_servo_duty_ramp.sv
// Self-checking bench for servo_duty_ramp: directed scenarios plus randomized traffic
// against an integer model of the slew/target rules.
module tb_servo_duty_ramp;
  import servo_duty_ramp_pkg::*;

  localparam int LOW      = 52;
  localparam int HIGH     = 102;
  localparam int STEP     = 1;
  localparam int SLEW     = 2;
  localparam int RATE_DIV = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  servo_duty_ramp_if bus();

  servo_duty_ramp #(
    .DUTYLOW  (LOW),
    .DUTYHIGH (HIGH),
    .DUTYSTEP (STEP),
    .SLEW     (SLEW),
    .RATE_DIV (RATE_DIV)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int total  = 0;
  int passes = 0;

  int m_duty, m_tgt, m_cnt;
  bit m_ready, m_busy, m_limit, m_sweep;

  task automatic checkOutput(input string name, input int act, input int exp);
    total++;
    if (act == exp) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  task automatic applyStimulus(input bit up, input bit dn, input bit valid, input int tgt,
                               input bit ps, input bit sweep);
    @(negedge clk);
    bus.step_up      = up;
    bus.step_dn      = dn;
    bus.tgt_valid    = valid;
    bus.tgt_duty     = duty_t'(tgt);
    bus.period_start = ps;
    bus.sweep_en     = sweep;
  endtask

  // n slew ticks worth of period pulses, each pulse followed by a quiet cycle
  task automatic ticks(input int n, input bit sweep);
    repeat (n * RATE_DIV) begin
      applyStimulus(0, 0, 0, 0, 1, sweep);
      applyStimulus(0, 0, 0, 0, 0, sweep);
    end
  endtask

  function automatic int clampInt(input int v);
    if (v < LOW) return LOW;
    if (v > HIGH) return HIGH;
    return v;
  endfunction

  task automatic modelStep();
    int  nd, nt, diff;
    bit  tick;
    tick = bus.period_start && (m_cnt == RATE_DIV - 1);
    if (bus.period_start) m_cnt = (m_cnt + 1) % RATE_DIV;
    nd = m_duty;
    if (tick && (m_duty != m_tgt)) begin
      diff = m_tgt - m_duty;
      if (diff > SLEW) diff = SLEW;
      if (diff < -SLEW) diff = -SLEW;
      nd = m_duty + diff;
    end
    nt = m_tgt;
    if (!m_sweep) begin
      if (bus.tgt_valid && m_ready) nt = clampInt(int'(bus.tgt_duty));
      else if (bus.step_up && !bus.step_dn) nt = clampInt(m_tgt + STEP);
      else if (bus.step_dn && !bus.step_up) nt = clampInt(m_tgt - STEP);
    end
`ifdef SERVO_AUTO_SWEEP_EN
    if (m_sweep) begin
      if (nd == m_tgt) begin
        if (bus.sweep_en) nt = (m_tgt == HIGH) ? LOW : HIGH;
        else m_sweep = 0;
      end
    end else if ((m_duty == m_tgt) && bus.sweep_en) begin
      nt = (m_duty == HIGH) ? LOW : HIGH;
      m_sweep = 1;
    end
`endif
    m_duty  = nd;
    m_tgt   = nt;
    m_busy  = (nt != nd);
    m_limit = (nt == LOW) || (nt == HIGH);
    m_ready = !m_sweep && (nt == nd);
  endtask

  // Model advances on every clock, or snaps to reset values the moment reset asserts
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_duty = LOW; m_tgt = LOW; m_cnt = 0;
      m_ready = 0; m_busy = 0; m_limit = 1; m_sweep = 0;
    end else begin
      modelStep();
    end
    #1;
    checkOutput("duty", int'(bus.duty), m_duty);
    checkOutput("busy", int'(bus.busy), int'(m_busy));
    checkOutput("at_limit", int'(bus.at_limit), int'(m_limit));
    checkOutput("tgt_ready", int'(bus.tgt_ready), int'(m_ready));
  end

  initial begin
    bit sweep_lvl;
    bus.step_up = 0; bus.step_dn = 0; bus.tgt_valid = 0; bus.tgt_duty = '0;
    bus.period_start = 0; bus.sweep_en = 0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);

    $display("[TB] T1 reset release");
    checkOutput("t1_duty", int'(bus.duty), 52);
    checkOutput("t1_ready", int'(bus.tgt_ready), 1);
    checkOutput("t1_busy", int'(bus.busy), 0);
    checkOutput("t1_limit", int'(bus.at_limit), 1);

    $display("[TB] T2 load 70");
    applyStimulus(0, 0, 1, 70, 0, 0);
    for (int k = 1; k <= 9; k++) begin
      ticks(1, 0);
      checkOutput("t2_duty", int'(bus.duty), 52 + 2 * k);
    end
    checkOutput("t2_busy", int'(bus.busy), 0);

    $display("[TB] T3 clamp and saturation");
    applyStimulus(0, 0, 1, 200, 0, 0);
    ticks(16, 0);
    checkOutput("t3_duty_high", int'(bus.duty), 102);
    checkOutput("t3_limit_high", int'(bus.at_limit), 1);
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t3_step_sat_busy", int'(bus.busy), 0);
    applyStimulus(0, 0, 1, 0, 0, 0);
    ticks(25, 0);
    checkOutput("t3_duty_low", int'(bus.duty), 52);
    checkOutput("t3_busy_low", int'(bus.busy), 0);

    $display("[TB] T4 simultaneous requests");
    applyStimulus(1, 1, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    checkOutput("t4_both_steps_busy", int'(bus.busy), 0);
    applyStimulus(1, 0, 1, 60, 0, 0);
    ticks(4, 0);
    checkOutput("t4_load_wins_duty", int'(bus.duty), 60);
    checkOutput("t4_load_wins_busy", int'(bus.busy), 0);

    $display("[TB] T5 no overshoot and reversal");
    applyStimulus(0, 0, 1, 71, 0, 0);
    ticks(6, 0);
    checkOutput("t5_duty_71", int'(bus.duty), 71);
    applyStimulus(0, 0, 1, 70, 0, 0);
    ticks(1, 0);
    checkOutput("t5_duty_70", int'(bus.duty), 70);
    checkOutput("t5_busy_70", int'(bus.busy), 0);
    applyStimulus(0, 0, 1, 52, 0, 0);
    ticks(9, 0);
    applyStimulus(0, 0, 1, 80, 0, 0);
    ticks(7, 0);
    checkOutput("t5_duty_66", int'(bus.duty), 66);
    repeat (20) applyStimulus(0, 1, 0, 0, 0, 0);
    ticks(1, 0);
    checkOutput("t5_reverse_64", int'(bus.duty), 64);
    ticks(2, 0);
    checkOutput("t5_settle_60", int'(bus.duty), 60);
    checkOutput("t5_settle_busy", int'(bus.busy), 0);

    $display("[TB] T6 sweep");
`ifdef SERVO_AUTO_SWEEP_EN
    ticks(21, 1);
    checkOutput("t6_leg1_duty", int'(bus.duty), 102);
    checkOutput("t6_leg1_busy", int'(bus.busy), 1);
    ticks(25, 1);
    checkOutput("t6_leg2_duty", int'(bus.duty), 52);
    ticks(5, 1);
    checkOutput("t6_mid_leg", int'(bus.duty), 62);
    ticks(20, 0);
    checkOutput("t6_stop_duty", int'(bus.duty), 102);
    checkOutput("t6_stop_busy", int'(bus.busy), 0);
    ticks(2, 0);
    checkOutput("t6_hold_duty", int'(bus.duty), 102);
`else
    ticks(5, 1);
    checkOutput("t6_no_sweep_duty", int'(bus.duty), 60);
    checkOutput("t6_no_sweep_busy", int'(bus.busy), 0);
`endif

    $display("[TB] reset mid-ramp");
    applyStimulus(0, 0, 1, 90, 0, 0);
    ticks(3, 0);
    applyStimulus(0, 0, 1, 75, 0, 0);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("rst_duty", int'(bus.duty), 52);
    checkOutput("rst_ready", int'(bus.tgt_ready), 0);
    repeat (2) applyStimulus(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    ticks(2, 0);
    checkOutput("rst_discard_duty", int'(bus.duty), 52);

    $display("[TB] random traffic");
    sweep_lvl = 0;
    for (int c = 0; c < 5000; c++) begin
      int tgt;
      if ($urandom_range(0, 599) == 0) begin
        @(negedge clk);
        #2 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
      end
      if ($urandom_range(0, 149) == 0) sweep_lvl = ~sweep_lvl;
      tgt = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023))
                                        : int'($urandom_range(40, 115));
      applyStimulus($urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                    $urandom_range(0, 5) == 0, tgt, $urandom_range(0, 2) == 0, sweep_lvl);
    end
    repeat (4) applyStimulus(0, 0, 0, 0, 0, 0);

    $display("%0d/%0d checks passed", passes, total);
    $finish;
  end
endmodule
